// File: rtl/rot_quad_gen_if.sv
// Command channel for the quadrature generator: valid/ready handshake plus
// per-command direction, detent count, phase dwell and the abort request.
interface rot_quad_gen_if #(
    parameter int CNT_W   = 8,
    parameter int DWELL_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [CNT_W-1:0]   cmd_count;
    logic [DWELL_W-1:0] cmd_dwell;
    logic               abort;

    modport master (
        output cmd_valid, cmd_dir, cmd_count, cmd_dwell, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_count, cmd_dwell, abort,
        output cmd_ready
    );
endinterface

// File: rtl/rot_quad_gen.sv
// Quadrature encoder emulator: step commands -> Gray-coded ROTa/ROTb detents, tracks position.
// Latency: first phase change D cycles after the accept edge, then one step every D cycles.
// Backpressure: cmd_ready only while idle; it rises on the done cycle so commands run back-to-back.
module rot_quad_gen #(
    parameter int CNT_W   = 8,
    parameter int DWELL_W = 16,
    parameter int POS_W   = 15
) (
    input  logic             clk,
    input  logic             reset,
    rot_quad_gen_if.slave    cmd,
    output logic             ROTa,
    output logic             ROTb,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos_out
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]   POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic               dir_q;
    logic [CNT_W-1:0]   left_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dcnt_q;
    logic [1:0]         phase_q;
    logic [1:0]         phase_nxt;
    logic [1:0]         ba_nxt;

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state == RUN);
    assign phase_nxt     = phase_q + 2'd1;

    // {B,A} for the next phase index; dir 1 is dir 0 with A and B swapped.
    always_comb begin
        ba_nxt = 2'b00;
        case (phase_nxt)
            2'd1:    ba_nxt = dir_q ? 2'b10 : 2'b01;
            2'd2:    ba_nxt = 2'b11;
            2'd3:    ba_nxt = dir_q ? 2'b01 : 2'b10;
            default: ba_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dir_q   <= 1'b0;
            left_q  <= '0;
            dwell_q <= DWELL_ONE;
            dcnt_q  <= DWELL_ONE;
            phase_q <= 2'd0;
            ROTa    <= 1'b0;
            ROTb    <= 1'b0;
            done    <= 1'b0;
            pos_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        if (cmd.cmd_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state   <= RUN;
                            dir_q   <= cmd.cmd_dir;
                            left_q  <= cmd.cmd_count;
                            dwell_q <= (cmd.cmd_dwell == '0) ? DWELL_ONE : cmd.cmd_dwell;
                            dcnt_q  <= DWELL_ONE;
                            phase_q <= 2'd0;
                        end
                    end
                end
                RUN: begin
                    if (dcnt_q == dwell_q) begin
                        dcnt_q        <= DWELL_ONE;
                        phase_q       <= phase_nxt;
                        {ROTb, ROTa}  <= ba_nxt;
                        if (phase_q == 2'd3) begin
                            // Detent closes at 00: account for it and decide whether to stop.
                            pos_out <= dir_q ? (pos_out - POS_ONE) : (pos_out + POS_ONE);
                            left_q  <= left_q - CNT_ONE;
                            if (left_q == CNT_ONE || cmd.abort) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else if (cmd.abort) begin
                            left_q <= CNT_ONE;
                        end
                    end else begin
                        dcnt_q <= dcnt_q + DWELL_ONE;
                        if (cmd.abort) begin
                            left_q <= CNT_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
